// File: rtl/sprite_renderer.sv
// sprite_renderer: walks a SPR_W x SPR_H window and streams sprite or background pixels to a VGA adapter
// Ports:
//    clock_i, reset_i              single clock, synchronous active-high reset
//    draw_char_i, draw_bg_i        one-cycle start pulses (BG wins if both arrive together)
//    x_i, y_i                      window top-left, latched on an accepted start
//    rom_addr_o, rd_x_o, rd_y_o    memory addresses, valid only while scanning, else 0
//    sprite_colour_i, bg_colour_i  memory read data, one cycle after the address
//    vga_x_o, vga_y_o, colour_o    registered pixel, held while plot_o is low
//    plot_o                        pixel write strobe
//    done_char_o, done_bg_o        one-cycle completion pulse for the active mode
//    busy_o                        high whenever not idle
module sprite_renderer #(
   parameter int         SPR_W       = 8,
   parameter int         SPR_H       = 8,
   parameter int         SCR_W       = 320,
   parameter int         SCR_H       = 240,
   parameter logic [2:0] TRANSPARENT = 3'b000
) (
   input  logic                             clock_i,
   input  logic                             reset_i,
   input  logic                             draw_char_i,
   input  logic                             draw_bg_i,
   input  logic [8:0]                       x_i,
   input  logic [7:0]                       y_i,
   output logic [$clog2(SPR_W*SPR_H)-1:0]   rom_addr_o,
   output logic [8:0]                       rd_x_o,
   output logic [7:0]                       rd_y_o,
   input  logic [2:0]                       sprite_colour_i,
   input  logic [2:0]                       bg_colour_i,
   output logic [8:0]                       vga_x_o,
   output logic [7:0]                       vga_y_o,
   output logic [2:0]                       colour_o,
   output logic                             plot_o,
   output logic                             done_char_o,
   output logic                             done_bg_o,
   output logic                             busy_o
);
   localparam int AW = $clog2(SPR_W*SPR_H);
   localparam int CW = SPR_W > 1 ? $clog2(SPR_W) : 1;
   localparam int RW = SPR_H > 1 ? $clog2(SPR_H) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [8:0]    x0_q, x0_d;
   logic [7:0]    y0_q, y0_d;
   logic          bg_q, bg_d;
   logic          drn_q, drn_d;
   logic          last_col, last_row, scan;
   logic [9:0]    sum_x;
   logic [8:0]    sum_y;
   logic          in_b;
   logic          s1_v_q, s1_in_q;
   logic [8:0]    s1_x_q;
   logic [7:0]    s1_y_q;
   logic          plot_d;
   logic [2:0]    pix_colour;

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      bg_d     = bg_q;
      drn_d    = drn_q;
      last_col = col_q == CW'(SPR_W - 1);
      last_row = row_q == RW'(SPR_H - 1);
      case (state_q)
         IDLE: if (draw_bg_i || draw_char_i) begin
            state_d = SCAN;
            x0_d    = x_i;
            y0_d    = y_i;
            bg_d    = draw_bg_i;
            col_d   = '0;
            row_d   = '0;
         end
         SCAN: begin
            col_d = last_col ? '0 : col_q + 1'b1;
            row_d = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
            drn_d = 1'b0;
            state_d = (last_col && last_row) ? DRAIN : SCAN;
         end
         DRAIN: begin
            drn_d   = 1'b1;
            state_d = drn_q ? DONE : DRAIN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         bg_q    <= 1'b0;
         drn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         bg_q    <= bg_d;
         drn_q   <= drn_d;
      end
   end

   // Bounds are judged on the unextended sums so off-screen pixels never wrap back on.
   assign scan       = state_q == SCAN;
   assign sum_x      = 10'(x0_q) + 10'(col_q);
   assign sum_y      = 9'(y0_q) + 9'(row_q);
   assign in_b       = (sum_x < 10'(SCR_W)) && (sum_y < 9'(SCR_H));
   assign rom_addr_o = scan ? AW'(int'(row_q) * SPR_W + int'(col_q)) : '0;
   assign rd_x_o     = scan ? sum_x[8:0] : '0;
   assign rd_y_o     = scan ? sum_y[7:0] : '0;

   // Stage 1 travels alongside the memory read; stage 2 qualifies with the returned colour.
   assign pix_colour = bg_q ? bg_colour_i : sprite_colour_i;
   assign plot_d     = s1_v_q && s1_in_q && (bg_q || sprite_colour_i != TRANSPARENT);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         s1_v_q   <= 1'b0;
         s1_in_q  <= 1'b0;
         s1_x_q   <= '0;
         s1_y_q   <= '0;
         plot_o   <= 1'b0;
         vga_x_o  <= '0;
         vga_y_o  <= '0;
         colour_o <= '0;
      end else begin
         s1_v_q   <= scan;
         s1_in_q  <= in_b;
         s1_x_q   <= sum_x[8:0];
         s1_y_q   <= sum_y[7:0];
         plot_o   <= plot_d;
         vga_x_o  <= plot_d ? s1_x_q : vga_x_o;
         vga_y_o  <= plot_d ? s1_y_q : vga_y_o;
         colour_o <= plot_d ? pix_colour : colour_o;
      end
   end

   assign busy_o      = state_q != IDLE;
   assign done_bg_o   = state_q == DONE && bg_q;
   assign done_char_o = state_q == DONE && !bg_q;
endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Pixel-drawing stage directly downstream of the sprite-movement FSM. It receives that FSM's `drawBG`/`drawChar` start pulses together with the latched `X`/`Y` position. It walks a SPR_W×SPR_H window pixel by pixel, fetching colour from a sprite ROM (character draw) or from the background memory (background restore). Each pixel goes to the VGA adapter as an `x`/`y`/`colour`/`plot` stream, and the stage returns a one-cycle `doneChar`/`doneBG` pulse when the window is complete.

## Interface
- `SPR_W`, 8: sprite width in pixels.
- `SPR_H`, 8: sprite height in pixels.
- `SCR_W`, 320: screen width; columns ≥ SCR_W are clipped.
- `SCR_H`, 240: screen height; rows ≥ SCR_H are clipped.
- `TRANSPARENT`, 3'b000: sprite colour key; not plotted in character mode.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `drawChar` in 1: one-cycle start of a sprite draw at `xIn`/`yIn`.
- `drawBG` in 1: one-cycle start of a background restore at `xIn`/`yIn`.
- `xIn` in 9: window top-left X; sampled on an accepted start.
- `yIn` in 8: window top-left Y; sampled on an accepted start.
- `romAddr` out clog2(SPR_W·SPR_H) (default 6): sprite ROM address, row·SPR_W+col.
- `rdX` out 9: background-memory read column.
- `rdY` out 8: background-memory read row.
- `spriteColour` in 3: sprite ROM data; 1-cycle read latency.
- `bgColour` in 3: background memory data; 1-cycle read latency.
- `vgaX` out 9: registered pixel column to the VGA adapter.
- `vgaY` out 8: registered pixel row to the VGA adapter.
- `colour` out 3: registered pixel colour to the VGA adapter.
- `plot` out 1: write strobe for `vgaX`/`vgaY`/`colour`.
- `doneChar` out 1: one-cycle pulse when a sprite draw completes.
- `doneBG` out 1: one-cycle pulse when a background restore completes.
- `busy` out 1: high in every non-IDLE state.

## Operation
- States: IDLE, SCAN, DRAIN, DONE. Reset forces IDLE.
- Reset values: every output register is 0, and the col/row counters are 0.
- **IDLE → SCAN** on `drawBG` or `drawChar`.
  - Latch `xIn`, `yIn` and the mode (BG or CHAR).
  - If both starts arrive in the same cycle, BG wins and `drawChar` is dropped.
  - Starts arriving in any state other than IDLE are ignored.
- **SCAN** lasts N = SPR_W·SPR_H cycles.
  - One pixel is issued per cycle in raster order: col 0..SPR_W−1 within row 0..SPR_H−1.
  - `romAddr` = row·SPR_W+col.
  - `rdX` = x0+col and `rdY` = y0+row, computed 10/9 bits wide and truncated on output.
  - Address outputs are combinational from the counters and are valid only in SCAN; they are 0 otherwise.
  - After the pixel (SPR_H−1, SPR_W−1) go to DRAIN.
- **DRAIN** lasts 2 cycles and flushes the 2-stage pipeline.
  - Stage 1 carries valid, the screen coordinates and an in-bounds flag alongside the memory read.
  - Stage 2 registers the VGA outputs.
- **DONE** lasts 1 cycle.
  - Pulse `doneBG` (BG mode) or `doneChar` (CHAR mode), then return to IDLE.
  - Only the pulse matching the mode fires.
- **Plot rule:** `plot` = stage-1 valid AND in-bounds AND (BG mode OR `spriteColour` ≠ TRANSPARENT).
  - In-bounds means unextended x0+col < SCR_W and y0+row < SCR_H.
  - BG mode uses `bgColour` and plots every in-bounds pixel, including colour 0.
  - When `plot` is 0, `vgaX`/`vgaY`/`colour` hold their previous values.
- **Clipped pixels** still consume their cycle, so total latency does not depend on position.
- **Reset mid-operation:**
  - Next cycle: IDLE, `plot` = 0, no done pulse.
  - A start in the cycle after reset deasserts is accepted.

## Timing
- Cycle 0 is the cycle in which the start is sampled.
- Pixel i address is presented in cycle i+1.
- Memory data for pixel i is valid in cycle i+2.
- `plot` for pixel i is high in cycle i+3.
- The last plot is in cycle N+2.
- The done pulse is in cycle N+3 (67 for the 8×8 default).
- `busy` is high in cycles 1..N+3 and low in cycle 0; it drops in cycle N+4.
- A new start is accepted from cycle N+4 onward (IDLE), giving a back-to-back period of N+4 cycles.
- The upstream FSM holds `X`/`Y` stable until it sees done, but this block does not rely on that: coordinates are latched at start.

## Test plan
- **Reset, then CHAR draw.** Reset; ROM returns 3'b101 for all addresses; `drawChar` at (1,16).
  - 64 plots at x 1..8, y 16..23 in raster order; first plot in cycle 3.
  - `doneChar` high only in cycle 67; `doneBG` stays 0.
- **Transparency.** ROM returns 0 for even addresses and 3'b110 for odd, at (40,40).
  - Exactly 32 plots, all at odd columns (x 41, 43, …), all with colour 3'b110.
  - Done in cycle 67.
- **BG restore.** `drawBG` at (5,5); `bgColour` = 0 for all reads.
  - 64 plots with colour 0; `rdX`/`rdY` sweep 5..12.
  - `doneBG` in cycle 67; `doneChar` stays 0.
- **Clipping.** `drawChar` at (316,236), all pixels opaque.
  - 16 plots, with x in 316..319 and y in 236..239.
  - No plot with x ≥ 320 or y ≥ 240, including no wrap-around.
  - Done still in cycle 67.
- **Start arbitration.**
  - `drawChar` pulsed in cycle 20 of an active draw is ignored: one done, 64 plots.
  - `drawBG` and `drawChar` asserted together: BG mode only, `doneBG` only.
- **Reset mid-draw.** Assert `reset` in cycle 30.
  - `plot`, `busy` and both done outputs are 0 from cycle 31.
  - A fresh `drawChar` then completes normally.
